// File: rtl/led_pio_arb_pkg.sv
// rtl/led_pio_arb_pkg.sv - shared types and constants for the LED PIO write arbiter
package led_pio_arb_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;
    localparam int PIO_DATA_ADDR = 0;
    localparam int AVALON_DATA_W = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner select starting after last_gnt
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    function automatic int wrap(input int base, input int k);
        return (base + k) % NREQ;
    endfunction

    // Scan from lowest to highest priority so the nearest requester after last_gnt wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[wrap(int'(last_gnt), k)]) begin
                gnt                           = '0;
                gnt[wrap(int'(last_gnt), k)]  = 1'b1;
                gnt_idx                       = IDX_W'(wrap(int'(last_gnt), k));
            end
        end
    end
endmodule

// File: rtl/led_pio_write_arbiter.sv
// rtl/led_pio_write_arbiter.sv - round-robin write/read-back/compare sequencer for the red-LED PIO
module led_pio_write_arbiter
    import led_pio_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = 18,
    parameter int ADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          ack,
    output logic                     ack_mismatch,
    output logic                     busy,
    output logic [DATA_W-1:0]        cur_value,
    output logic [ADDR_W-1:0]        pio_address,
    output logic                     pio_chipselect,
    output logic                     pio_write_n,
    output logic [31:0]              pio_writedata,
    input  logic [31:0]              pio_readdata
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t                  state, state_nx;
    logic [IDX_W-1:0]        owner, owner_nx;
    logic [IDX_W-1:0]        last_gnt, last_gnt_nx;
    logic [DATA_W-1:0]       lat_data, lat_data_nx;
    logic [DATA_W-1:0]       cur_value_nx;
    logic [NREQ-1:0]         ack_nx;
    logic                    ack_mismatch_nx;
    logic                    busy_nx;
    logic                    cs_nx;
    logic                    write_n_nx;
    logic [31:0]             writedata_nx;
    logic [NREQ-1:0]         gnt;
    logic [IDX_W-1:0]        gnt_idx;
    logic [DATA_W-1:0]       win_data;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    assign win_data    = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    assign pio_address = ADDR_W'(PIO_DATA_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            owner          <= '0;
            last_gnt       <= IDX_W'(NREQ - 1);
            lat_data       <= '0;
            cur_value      <= '0;
            ack            <= '0;
            ack_mismatch   <= 1'b0;
            busy           <= 1'b0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            state          <= state_nx;
            owner          <= owner_nx;
            last_gnt       <= last_gnt_nx;
            lat_data       <= lat_data_nx;
            cur_value      <= cur_value_nx;
            ack            <= ack_nx;
            ack_mismatch   <= ack_mismatch_nx;
            busy           <= busy_nx;
            pio_chipselect <= cs_nx;
            pio_write_n    <= write_n_nx;
            pio_writedata  <= writedata_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = WRITE;
            WRITE:   state_nx = READ;
            READ:    state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Computes the value each output register takes in the next cycle.
    always_comb begin
        owner_nx        = owner;
        last_gnt_nx     = last_gnt;
        lat_data_nx     = lat_data;
        cur_value_nx    = cur_value;
        ack_nx          = '0;
        ack_mismatch_nx = 1'b0;
        cs_nx           = 1'b0;
        write_n_nx      = 1'b1;
        writedata_nx    = pio_writedata;
        busy_nx         = (state_nx != IDLE);
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_nx     = gnt_idx;
                    last_gnt_nx  = gnt_idx;
                    lat_data_nx  = win_data;
                    cs_nx        = 1'b1;
                    write_n_nx   = 1'b0;
                    writedata_nx = AVALON_DATA_W'(win_data);
                end
            end
            WRITE: begin
                cs_nx        = 1'b1;
                cur_value_nx = lat_data;
            end
            READ: begin
                // Whole-word compare also catches nonzero bits above DATA_W.
                ack_nx[owner]   = 1'b1;
                ack_mismatch_nx = (pio_readdata != AVALON_DATA_W'(lat_data));
            end
            default: ;
        endcase
    end
endmodule
